// File: rtl/cga_vram_arbiter.sv
// Arbitrates the CGA 8-bit video RAM port between display fetch and one queued CPU access.
// Optional CGA_VRAM_WAIT_EN: when defined, bus_rdy inserts ISA wait states; otherwise it stays 1.
module cga_vram_arbiter #(
  parameter logic [18:0] VRAM_BASE  = 19'h08000,
  parameter logic [4:0]  SLOT_START = 5'd8,
  parameter logic [4:0]  SLOT_END   = 5'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  clk_seq,
  input  logic        disp_active,
  input  logic [18:0] disp_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        bus_rdy,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_we_l,
  input  logic [7:0]  ram_din,
  output logic [15:0] conflict_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        rdy_q, rdy_d;
  logic        we_l_q, we_l_d;
  logic [7:0]  dout_q, dout_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_slot;
  logic        cpu_owns_ram;

  assign in_slot = (clk_seq >= SLOT_START) && (clk_seq <= (SLOT_END - 5'd1));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    rdy_d   = rdy_q;
    we_l_d  = 1'b1;
    dout_d  = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_WAIT;
`ifdef CGA_VRAM_WAIT_EN
          rdy_d   = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (!disp_active && in_slot) begin
          state_d = S_ADDR;
          we_l_d  = ~we_q;
          dout_d  = we_q ? wdata_q : '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ADDR: begin
        state_d = disp_active ? S_WAIT : S_DATA;
      end
      S_DATA: begin
        if (disp_active) begin
          state_d = S_WAIT;
        end else begin
          if (!we_q) rdata_d = ram_din;
          state_d = S_DONE;
          ack_d   = 1'b1;
          rdy_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b1;
      we_l_q  <= 1'b1;
      dout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      we_l_q  <= we_l_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  // A display fetch landing in ADDR must still suppress the already-registered strobe.
  assign cpu_owns_ram = ((state_q == S_ADDR) || (state_q == S_DATA)) && !disp_active;
  assign ram_a        = cpu_owns_ram ? (VRAM_BASE | {4'b0, addr_q}) : disp_addr;
  assign ram_we_l     = we_l_q | disp_active;

  assign cpu_rdata    = rdata_q;
  assign cpu_ack      = ack_q;
  assign bus_rdy      = rdy_q;
  assign ram_dout     = dout_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Randomised and directed bench for cga_vram_arbiter against a transaction-level reference model.
module tb_cga_vram_arbiter;

  localparam int VRAM_BASE  = 'h08000;
  localparam int SLOT_START = 8;
  localparam int SLOT_END   = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  clk_seq;
  logic        disp_active;
  logic [18:0] disp_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        bus_rdy;
  logic [18:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we_l;
  logic [7:0]  ram_din;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  cga_vram_arbiter #(
    .VRAM_BASE (19'h08000),
    .SLOT_START(5'd8),
    .SLOT_END  (5'd15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_seq     (clk_seq),
    .disp_active (disp_active),
    .disp_addr   (disp_addr),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .bus_rdy     (bus_rdy),
    .ram_a       (ram_a),
    .ram_dout    (ram_dout),
    .ram_we_l    (ram_we_l),
    .ram_din     (ram_din),
    .conflict_cnt(conflict_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int acks_seen = 0;

  // Reference model: a pending request and how far its RAM access has progressed.
  // m_stage: 0 = queued waiting for a free slot, 1 = address cycle, 2 = data cycle, 3 = acknowledged
  bit m_busy;
  int m_stage;
  bit m_we;
  int m_addr;
  int m_wdata;
  int m_cnt;
  int m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit slot_open();
    return !disp_active && (int'(clk_seq) >= SLOT_START) && (int'(clk_seq) < SLOT_END);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_busy = 0; m_stage = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_cnt = 0; m_rdata = 0;
    end else if (!m_busy) begin
      if (cpu_req) begin
        m_busy = 1; m_stage = 0; m_we = cpu_we; m_addr = int'(cpu_addr); m_wdata = int'(cpu_wdata);
      end
    end else begin
      case (m_stage)
        0: if (slot_open()) m_stage = 1;
           else if (m_cnt < 65535) m_cnt = m_cnt + 1;
        1: m_stage = disp_active ? 0 : 2;
        2: if (disp_active) m_stage = 0;
           else begin
             if (!m_we) m_rdata = int'(ram_din);
             m_stage = 3;
           end
        default: m_busy = 0;
      endcase
    end
  endtask

  task automatic tick();
    int exp_a;
    bit cpu_on_bus;
    #1;
    if (chk_en) begin
      cpu_on_bus = m_busy && (m_stage == 1 || m_stage == 2) && !disp_active;
      exp_a = cpu_on_bus ? (VRAM_BASE | m_addr) : int'(disp_addr);
      check_eq("ram_a", ram_a, exp_a);
      check_eq("ram_we_l", ram_we_l, (m_busy && m_stage == 1 && m_we && !disp_active) ? 0 : 1);
    end
    @(posedge clk);
    #1;
    model_edge();
    if (cpu_ack === 1'b1) acks_seen++;
    if (chk_en) begin
      check_eq("cpu_ack", cpu_ack, (m_busy && m_stage == 3) ? 1 : 0);
`ifdef CGA_VRAM_WAIT_EN
      check_eq("bus_rdy", bus_rdy, (m_busy && m_stage != 3) ? 0 : 1);
`else
      check_eq("bus_rdy", bus_rdy, 1);
`endif
      check_eq("cpu_rdata", cpu_rdata, m_rdata);
      check_eq("ram_dout", ram_dout, (m_busy && m_stage == 1 && m_we) ? m_wdata : 0);
      check_eq("conflict_cnt", conflict_cnt, m_cnt);
    end
    cpu_req = 1'b0;
    clk_seq = clk_seq + 5'd1;
  endtask

  task automatic issue(input bit we, input logic [14:0] a, input logic [7:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    tick();
  endtask

  task automatic run_until_ack(input int max, input string tag);
    int start = acks_seen;
    int n = 0;
    while (acks_seen == start && n < max) begin
      tick();
      n++;
    end
    check_eq({tag, "_acks"}, acks_seen - start, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [18:0] da;
    reset = 1'b1; clk_seq = '0; disp_active = 1'b0; disp_addr = 19'h12345;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; ram_din = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_rdy", bus_rdy, 1);
    check_eq("rst_ack", cpu_ack, 0);
    check_eq("rst_rdata", cpu_rdata, 0);
    check_eq("rst_we_l", ram_we_l, 1);
    check_eq("rst_dout", ram_dout, 0);
    check_eq("rst_cnt", conflict_cnt, 0);

    // Best-case write in an open slot
    clk_seq = 5'd8;
    issue(1'b1, 15'h0123, 8'hA5);
    tick();
    #1;
    check_eq("wr_ram_a", ram_a, 19'h08123);
    check_eq("wr_we_l", ram_we_l, 0);
    check_eq("wr_dout", ram_dout, 8'hA5);
    tick();
    tick();
    check_eq("wr_ack_c4", cpu_ack, 1);
    tick();

    // Read starting outside the slot: six conflict cycles at phases 2..7
    clk_seq = 5'd1; ram_din = 8'h3C;
    issue(1'b0, 15'h7FFF, 8'h00);
    run_until_ack(40, "rd");
    check_eq("rd_rdata", cpu_rdata, 8'h3C);
    check_eq("rd_cnt", conflict_cnt, 6);
    tick();

    // Request at the last phase of the window waits for the next frame
    clk_seq = 5'd15;
    issue(1'b0, 15'h0456, 8'h00);
    s = acks_seen;
    for (int i = 0; i < 60 && acks_seen == s; i++) begin
      disp_active = (clk_seq < 5'd8) || (clk_seq > 5'd15);
      disp_addr = 19'($urandom);
      ram_din = 8'h5A;
      tick();
    end
    disp_active = 1'b0;
    check_eq("wrap_acks", acks_seen - s, 1);
    check_eq("wrap_cnt", conflict_cnt, 30);
    tick();

    // Display steals the data cycle: access is reissued, single ack
    clk_seq = 5'd8;
    s = acks_seen;
    issue(1'b1, 15'h0777, 8'h3E);
    tick();
    tick();
    disp_active = 1'b1; da = 19'h4ABCD; disp_addr = da;
    #1;
    check_eq("dd_ram_a", ram_a, da);
    tick();
    disp_active = 1'b0;
    run_until_ack(20, "dd");
    for (int i = 0; i < 5; i++) tick();
    check_eq("dd_single_ack", acks_seen - s, 1);

    // Saturate the conflict counter; a second request while waiting is dropped
    disp_active = 1'b1; ram_din = 8'hC3;
    issue(1'b0, 15'h0011, 8'h00);
    for (int i = 0; i < 100; i++) tick();
    issue(1'b1, 15'h2222, 8'h99);
    for (int i = 0; i < 65500; i++) tick();
    check_eq("sat_cnt", conflict_cnt, 16'hFFFF);
    s = acks_seen;
    disp_active = 1'b0;
    run_until_ack(40, "sat");
    check_eq("sat_rdata", cpu_rdata, 8'hC3);
    check_eq("sat_cnt_hold", conflict_cnt, 16'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    check_eq("sat_single_ack", acks_seen - s, 1);

    // Reset in the middle of a write's address cycle
    clk_seq = 5'd8;
    s = acks_seen;
    issue(1'b1, 15'h0055, 8'h66);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_mid_we_l", ram_we_l, 1);
    check_eq("rst_mid_cnt", conflict_cnt, 0);
    check_eq("rst_mid_rdy", bus_rdy, 1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("rst_mid_no_ack", acks_seen - s, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      disp_active = ($urandom_range(0, 3) == 0);
      disp_addr   = 19'($urandom);
      ram_din     = 8'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 4) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom);
        cpu_addr  = 15'($urandom);
        cpu_wdata = 8'($urandom);
      end
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
